// File: rtl/calc_param_if.sv
// Key-command input and display/status outputs of the calc_param core.
interface calc_param_if #(
  parameter int NDIGITS = 8,
  parameter int POSW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
);
  logic [3:0]      cmd;
  logic            cmd_valid;
  logic [1:0]      status;
  logic [3:0]      data;
  logic [POSW-1:0] pos;
  logic            data_valid;
  logic            neg;
  logic [2:0]      EA;

  modport master (
    output cmd, cmd_valid,
    input  status, data, pos, data_valid, neg, EA
  );

  modport slave (
    input  cmd, cmd_valid,
    output status, data, pos, data_valid, neg, EA
  );
endinterface

// File: rtl/calc_param.sv
// Decimal calculator core: digit entry, add/sub, shift-add multiply, and a
// digit-serial print of every operand change and result.
module calc_param #(
  parameter int  NDIGITS = 8,
  parameter int  WIDTH   = 27,
  localparam int POSW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input logic         clock,
  input logic         reset,
  calc_param_if.slave bus
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [AW-1:0] pow10(input int n);
    logic [AW-1:0] p;
    p = AW'(1);
    for (int i = 0; i < n; i++) p = p * AW'(10);
    return p;
  endfunction

  function automatic logic [3:0] lsd(input logic [WIDTH-1:0] v);
    return 4'(v % WIDTH'(10));
  endfunction

  localparam logic [AW-1:0]    MAXV   = pow10(NDIGITS) - AW'(1);
  localparam logic [AW-1:0]    MAXNEG = pow10(NDIGITS - 1) - AW'(1);
  localparam logic [WIDTH-1:0] LIMIT  = WIDTH'(pow10(NDIGITS - 1));
  localparam logic [POSW-1:0]  LAST   = POSW'(NDIGITS - 1);

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_CLR = 4'hD;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_BS  = 4'hF;

  // Encoding is visible on EA, so the values are fixed.
  typedef enum logic [2:0] {
    S_WAIT_A = 3'd0,
    S_WAIT_B = 3'd1,
    S_OP     = 3'd2,
    S_CALC   = 3'd3,
    S_ERR    = 3'd4,
    S_PRINT  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           r_ret;
  logic [WIDTH-1:0] r_entry;
  logic [WIDTH-1:0] r_rega;
  logic [WIDTH-1:0] r_regb;
  logic [WIDTH-1:0] r_pval;
  logic [3:0]       r_op;
  logic             r_neg;
  logic             r_fresh;
  logic             r_dv;
  logic [3:0]       r_data;
  logic [POSW-1:0]  r_pos;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;

  logic             w_ready;
  logic             w_acc;
  logic             w_clear;
  logic             w_is_dig;
  logic             w_is_op;
  logic             w_dig_ok;
  logic             w_res_neg;
  logic             w_err;
  logic             w_mul_busy;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_dig_val;
  logic [WIDTH-1:0] w_bs_val;
  logic [WIDTH-1:0] w_res_w;
  logic [AW-1:0]    w_acc_next;
  logic [AW-1:0]    w_res;
  logic [POSW-1:0]  w_pos_next;

  assign w_ready  = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) || (r_state == S_OP);
  assign w_acc    = bus.cmd_valid && w_ready;
  assign w_clear  = bus.cmd_valid && (bus.cmd == K_CLR);
  assign w_is_dig = (bus.cmd <= 4'd9);
  assign w_is_op  = (bus.cmd == K_ADD) || (bus.cmd == K_SUB) || (bus.cmd == K_MUL);

  // A digit after a result, or the first digit of operand B, starts from zero.
  assign w_base     = ((r_state == S_OP) || r_fresh) ? '0 : r_entry;
  assign w_dig_ok   = (w_base < LIMIT);
  assign w_dig_val  = w_base * WIDTH'(10) + WIDTH'(bus.cmd);
  assign w_bs_val   = r_entry / WIDTH'(10);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_busy = (r_op == K_MUL) && (r_cnt != '0);
  assign w_pos_next = r_pos + POSW'(1);

  always_comb begin
    w_res     = '0;
    w_res_neg = 1'b0;
    case (r_op)
      K_ADD: w_res = AW'(r_rega) + AW'(r_regb);
      K_SUB: begin
        if (r_rega >= r_regb) begin
          w_res = AW'(r_rega - r_regb);
        end else begin
          w_res     = AW'(r_regb - r_rega);
          w_res_neg = 1'b1;
        end
      end
      default: w_res = w_acc_next;
    endcase
  end

  assign w_err   = (w_res > MAXV) || (w_res_neg && (w_res > MAXNEG));
  assign w_res_w = w_res[WIDTH-1:0];

  always_comb begin
    case (r_state)
      S_CALC:  bus.status = 2'b01;
      S_ERR:   bus.status = 2'b00;
      S_PRINT: bus.status = 2'b11;
      default: bus.status = 2'b10;
    endcase
  end

  assign bus.EA         = r_state;
  assign bus.data       = r_data;
  assign bus.pos        = r_pos;
  assign bus.data_valid = r_dv;
  assign bus.neg        = r_neg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT_A;
      r_ret    <= S_WAIT_A;
      r_entry  <= '0;
      r_rega   <= '0;
      r_regb   <= '0;
      r_pval   <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_fresh  <= 1'b0;
      r_dv     <= 1'b0;
      r_data   <= '0;
      r_pos    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_clear) begin
      r_rega  <= '0;
      r_regb  <= '0;
      r_entry <= '0;
      r_neg   <= 1'b0;
      r_fresh <= 1'b0;
      r_state <= S_PRINT;
      r_ret   <= S_WAIT_A;
      r_pos   <= '0;
      r_dv    <= 1'b1;
      r_data  <= 4'd0;
      r_pval  <= '0;
    end else begin
      case (r_state)
        S_WAIT_A, S_WAIT_B: begin
          if (w_acc) begin
            if (w_is_dig) begin
              if (w_dig_ok) begin
                r_entry <= w_dig_val;
                r_neg   <= 1'b0;
                r_fresh <= 1'b0;
                r_state <= S_PRINT;
                r_ret   <= r_state;
                r_pos   <= '0;
                r_dv    <= 1'b1;
                r_data  <= lsd(w_dig_val);
                r_pval  <= w_dig_val / WIDTH'(10);
              end
            end else if (bus.cmd == K_BS) begin
              r_entry <= w_bs_val;
              r_state <= S_PRINT;
              r_ret   <= r_state;
              r_pos   <= '0;
              r_dv    <= 1'b1;
              r_data  <= (r_neg && (LAST == '0)) ? 4'hA : lsd(w_bs_val);
              r_pval  <= w_bs_val / WIDTH'(10);
            end else if (w_is_op && (r_state == S_WAIT_A) && !r_neg) begin
              r_rega  <= r_entry;
              r_op    <= bus.cmd;
              r_entry <= '0;
              r_fresh <= 1'b0;
              r_state <= S_OP;
            end else if ((bus.cmd == K_EQ) && (r_state == S_WAIT_B)) begin
              r_regb   <= r_entry;
              r_acc    <= '0;
              r_mcand  <= AW'(r_rega);
              r_mplier <= r_entry;
              r_cnt    <= CW'(WIDTH - 1);
              r_state  <= S_CALC;
            end
          end
        end
        S_OP: begin
          if (w_acc) begin
            if (w_is_op) begin
              r_op <= bus.cmd;
            end else if (w_is_dig) begin
              r_entry <= w_dig_val;
              r_state <= S_PRINT;
              r_ret   <= S_WAIT_B;
              r_pos   <= '0;
              r_dv    <= 1'b1;
              r_data  <= lsd(w_dig_val);
              r_pval  <= w_dig_val / WIDTH'(10);
            end
          end
        end
        S_CALC: begin
          // The last multiply step is folded into the result compare.
          if (w_mul_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
          end else if (w_err) begin
            r_state <= S_ERR;
          end else begin
            r_entry <= w_res_w;
            r_neg   <= w_res_neg;
            r_fresh <= 1'b1;
            r_state <= S_PRINT;
            r_ret   <= S_WAIT_A;
            r_pos   <= '0;
            r_dv    <= 1'b1;
            r_data  <= (w_res_neg && (LAST == '0)) ? 4'hA : lsd(w_res_w);
            r_pval  <= w_res_w / WIDTH'(10);
          end
        end
        S_PRINT: begin
          if (r_pos == LAST) begin
            r_dv    <= 1'b0;
            r_state <= r_ret;
          end else begin
            r_pos  <= w_pos_next;
            r_data <= (r_neg && (w_pos_next == LAST)) ? 4'hA : lsd(r_pval);
            r_pval <= r_pval / WIDTH'(10);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_param.sv
// Directed and random key sequences for calc_param, checked against an
// arithmetic reference model of the calculator.
module tb_calc_param;

  localparam int ND    = 8;
  localparam int WIDTH = 27;
  localparam int M_A   = 0;
  localparam int M_B   = 1;
  localparam int M_OP  = 2;
  localparam int M_ERR = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  calc_param_if #(.NDIGITS(ND)) bus ();

  calc_param #(.NDIGITS(ND), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  longint     m_entry;
  longint     m_rega;
  int         m_mode;
  logic [3:0] m_op;
  bit         m_neg;
  bit         m_fresh;

  function automatic longint p10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit(input longint v, input bit ng, input int p);
    if (ng && (p == ND - 1)) return 4'hA;
    return 4'((v / p10(p)) % 10);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_entry = 0;
    m_rega  = 0;
    m_mode  = M_A;
    m_op    = 4'hC;
    m_neg   = 1'b0;
    m_fresh = 1'b0;
  endtask

  // Calculator behaviour as a user sees it; returns what the display should do.
  task automatic model(input logic [3:0] k, output int kind, output longint v,
                       output bit ng, output int lat);
    longint base, a, b, r;
    bit     rn;
    kind = 0; v = 0; ng = 1'b0; lat = 1;
    if (k == 4'hD) begin
      model_reset();
      kind = 1;
      return;
    end
    if (m_mode == M_ERR) return;
    if (k <= 4'd9) begin
      if (m_mode == M_OP) begin
        m_entry = longint'(k);
        m_mode  = M_B;
        kind    = 1;
        v       = m_entry;
      end else begin
        base = m_fresh ? 0 : m_entry;
        if (base < p10(ND - 1)) begin
          m_entry = base * 10 + longint'(k);
          m_neg   = 1'b0;
          m_fresh = 1'b0;
          kind    = 1;
          v       = m_entry;
        end
      end
    end else if (k <= 4'hC) begin
      if (m_mode == M_OP) begin
        m_op = k;
      end else if ((m_mode == M_A) && !m_neg) begin
        m_rega  = m_entry;
        m_op    = k;
        m_entry = 0;
        m_fresh = 1'b0;
        m_mode  = M_OP;
      end
    end else if (k == 4'hF) begin
      if (m_mode != M_OP) begin
        m_entry = m_entry / 10;
        kind    = 1;
        v       = m_entry;
        ng      = m_neg;
      end
    end else if ((k == 4'hE) && (m_mode == M_B)) begin
      a  = m_rega;
      b  = m_entry;
      rn = 1'b0;
      if (m_op == 4'hA) r = a + b;
      else if (m_op == 4'hB) begin
        if (a >= b) r = a - b;
        else begin r = b - a; rn = 1'b1; end
      end else r = a * b;
      lat = (m_op == 4'hC) ? WIDTH + 1 : 2;
      if ((r > p10(ND) - 1) || (rn && (r > p10(ND - 1) - 1))) begin
        m_mode = M_ERR;
        kind   = 2;
      end else begin
        m_entry = r;
        m_neg   = rn;
        m_fresh = 1'b1;
        m_mode  = M_A;
        kind    = 1;
        v       = r;
        ng      = rn;
      end
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.cmd       = k;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_print(input longint v, input bit ng, input int lat, input int first);
    for (int c = 1; c < lat; c++) begin
      chk("busy_status", 64'(bus.status), 64'(1));
      chk("busy_dv", 64'(bus.data_valid), 64'(0));
      @(negedge clock);
    end
    for (int p = first; p < ND; p++) begin
      chk("beat_dv", 64'(bus.data_valid), 64'(1));
      chk("beat_pos", 64'(bus.pos), 64'(p));
      chk("beat_data", 64'(bus.data), 64'(exp_digit(v, ng, p)));
      chk("beat_status", 64'(bus.status), 64'(3));
      chk("beat_neg", 64'(bus.neg), 64'(ng));
      @(negedge clock);
    end
    chk("post_status", 64'(bus.status), 64'(2));
    chk("post_dv", 64'(bus.data_valid), 64'(0));
    chk("post_pos", 64'(bus.pos), 64'(ND - 1));
    chk("post_ea", 64'(bus.EA), 64'(m_mode));
  endtask

  task automatic expect_err(input int lat);
    for (int c = 1; c < lat; c++) begin
      chk("busy_status", 64'(bus.status), 64'(1));
      @(negedge clock);
    end
    chk("err_status", 64'(bus.status), 64'(0));
    chk("err_dv", 64'(bus.data_valid), 64'(0));
    chk("err_ea", 64'(bus.EA), 64'(M_ERR));
  endtask

  task automatic expect_none();
    chk("idle_dv", 64'(bus.data_valid), 64'(0));
    chk("idle_status", 64'(bus.status), (m_mode == M_ERR) ? 64'(0) : 64'(2));
    chk("idle_ea", 64'(bus.EA), 64'(m_mode));
  endtask

  task automatic key(input logic [3:0] k);
    int     kind, lat;
    longint v;
    bit     ng;
    model(k, kind, v, ng, lat);
    press(k);
    if (kind == 1) expect_print(v, ng, lat, 0);
    else if (kind == 2) expect_err(lat);
    else expect_none();
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      key((c >= "A") ? 4'(c - "A" + 10) : 4'(c - "0"));
    end
  endtask

  task automatic check_reset_values();
    chk("rst_status", 64'(bus.status), 64'(2));
    chk("rst_ea", 64'(bus.EA), 64'(0));
    chk("rst_data", 64'(bus.data), 64'(0));
    chk("rst_pos", 64'(bus.pos), 64'(0));
    chk("rst_dv", 64'(bus.data_valid), 64'(0));
    chk("rst_neg", 64'(bus.neg), 64'(0));
  endtask

  initial begin
    int         kind, lat, r;
    longint     v;
    bit         ng;
    logic [3:0] k;

    bus.cmd       = 4'd0;
    bus.cmd_valid = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_values();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    keys("123");
    keys("D45A7E");
    keys("A8E");
    keys("D3B10E");
    keys("A5");
    keys("D0B9999999E");
    keys("D0B99999999E");
    keys("D");
    keys("D99999999A0E");
    keys("A1E");
    keys("D1234C5678E");
    keys("D99999C99999E");
    keys("5");
    keys("D");
    keys("D123456789F");
    keys("DF");

    keys("D");
    model(4'd4, kind, v, ng, lat);
    press(4'd4);
    press(4'd7);
    expect_print(v, ng, lat, 1);

    model(4'd5, kind, v, ng, lat);
    press(4'd5);
    model(4'hD, kind, v, ng, lat);
    press(4'hD);
    expect_print(v, ng, lat, 0);

    keys("6C7");
    model(4'hE, kind, v, ng, lat);
    press(4'hE);
    repeat (3) @(negedge clock);
    chk("calc_busy", 64'(bus.status), 64'(1));
    model(4'hD, kind, v, ng, lat);
    press(4'hD);
    expect_print(v, ng, lat, 0);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) k = 4'($urandom_range(0, 9));
      else if (r < 70) k = 4'($urandom_range(10, 12));
      else if (r < 82) k = 4'hE;
      else if (r < 93) k = 4'hF;
      else k = 4'hD;
      key(k);
      if (m_mode == M_ERR) key(4'hD);
    end

    keys("D12C34");
    model(4'hE, kind, v, ng, lat);
    press(4'hE);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < WIDTH + 5; c++) begin
      @(negedge clock);
      chk("after_rst_dv", 64'(bus.data_valid), 64'(0));
    end
    keys("7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_param.md
# calc_param

Parametrised decimal calculator core. It accepts one-hot-timed 4-bit key commands, builds two decimal operands, and computes add, subtract or multiply. Multiply uses an iterative shift-add. Every operand change and every result is serialised digit-by-digit to the display controller over `data`/`pos`. It adds several features: configurable digit count, a valid-qualified command input, a sign indicator, overflow error, a clear key, and result chaining.

## Interface
- `NDIGITS`, 8: display digit count; operand and result magnitude limit is 10^NDIGITS−1.
- `WIDTH`, 27: operand register width; must satisfy 2^WIDTH > 10^NDIGITS.
- `POSW`, $clog2(NDIGITS) (min 1): derived, width of `pos`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd` in 4: key code.
  - 0–9 digit.
  - 1010 add, 1011 sub, 1100 mul.
  - 1101 clear, 1110 '=', 1111 backspace.
- `cmd_valid` in 1: `cmd` is presented this cycle.
- `status` out 2: 00 error, 01 busy, 10 ready, 11 printing.
- `data` out 4: BCD digit, or 4'hA for '−'.
- `pos` out POSW: digit position, 0 = least significant.
- `data_valid` out 1: `data`/`pos` valid this cycle.
- `neg` out 1: displayed value is negative.
- `EA` out 3: current state, for debug.
  - 0 WAIT_A, 1 WAIT_B, 2 OP, 3 CALC, 4 ERR, 5 PRINT.

## Operation
- A command is accepted only when `cmd_valid` is high and `status` is 10.
  - The exception is clear (1101), which is accepted whenever `cmd_valid` is high, in any state including ERR, PRINT and CALC.
  - Commands that are not accepted are dropped, not queued.
- Clear zeroes regA, regB, the entry register and `neg`, moves to WAIT_A, and prints 0.
- WAIT_A:
  - Digit: entry = entry·10 + cmd, but only if entry < 10^(NDIGITS−1); otherwise the digit is ignored with no print. A print follows an accepted digit.
  - Backspace: entry = entry/10, then print.
  - Operator: regA ← entry, op latched, entry ← 0, go to OP with no print.
  - '=' is ignored.
- OP:
  - Another operator replaces op.
  - Digit: entry ← cmd, go to WAIT_B, print.
  - Backspace and '=' are ignored.
- WAIT_B:
  - Digit and backspace behave as in WAIT_A.
  - Operator is ignored.
  - '=': regB ← entry, go to CALC.
- CALC (`status` 01):
  - add: one cycle, result = regA + regB.
  - sub: one cycle. If regA ≥ regB, result = regA − regB with `neg` = 0; otherwise result = regB − regA with `neg` = 1.
  - mul: WIDTH cycles of shift-add into a 2·WIDTH accumulator.
  - Error check: result > 10^NDIGITS−1, or `neg` with result > 10^(NDIGITS−1)−1, goes to ERR.
  - On success: entry ← result, go to PRINT, then return to WAIT_A.
- Chaining: an operator in WAIT_A after a result uses that result as regA.
  - If `neg` = 1, the operator is ignored until clear or a new digit.
  - A new digit clears `neg` and starts a fresh entry from 0.
- ERR: `status` = 00 and `data_valid` = 0. Only clear or reset leave this state.
- PRINT emits NDIGITS beats, one per cycle, for pos = 0…NDIGITS−1.
  - data = value mod 10, then value /= 10.
  - When `neg` = 1, the beat at pos NDIGITS−1 carries 4'hA.
  - Leading zeros are sent as 0; blanking is left to the display controller.

## Timing
- Reset values:
  - `status` = 10, `EA` = WAIT_A.
  - `data` = 0, `pos` = 0, `data_valid` = 0, `neg` = 0.
  - All internal registers = 0.
- Digit or backspace accepted at edge N: `status` = 11 from N+1, beats at N+1…N+NDIGITS, `status` = 10 at N+NDIGITS+1.
- '=' at edge N:
  - add/sub: CALC in cycle N+1, beats at N+2…N+NDIGITS+1.
  - mul: CALC for cycles N+1…N+WIDTH, beats start at N+WIDTH+1.
- `data_valid` is high exactly on beat cycles. `pos` holds its last value otherwise.
- Clear during PRINT or CALC aborts that activity. The next cycle starts a fresh 0-print.
- Reset mid-operation returns all outputs to reset values immediately, asynchronously.

## Test plan
- Reset, then keys 1,2,3: three prints, each 8 beats. The last print shows data 3,2,1,0,0,0,0,0; `status` returns to 10.
- 4,5 + 7 '=' (add): result beats 2,5,0… The next key '+', 8, '=' chains to print 60.
- 3 − 1,0 '=': `neg` = 1, beats 7,0,0,0,0,0,0,A.
  - With NDIGITS = 4: 0 − 9,9,9,9 leads to ERR.
- 1,2,3,4 × 5,6,7,8 '=' (NDIGITS = 8): busy for WIDTH cycles, then print of 7006652.
  - 9,9,9,9,9 × 9,9,9,9,9 leads to ERR with `status` 00.
  - Clear then restores `status` 10 and a print of 0.
- Edge and drop cases:
  - Nine digits 1…9 entered: the ninth is ignored.
  - Backspace from 0 prints 0.
  - Keys sent while `status` = 11 are dropped.
  - Clear mid-print aborts the print.
  - Reset asserted mid-multiply gives reset values with no further beats.
